// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill engine: one miss at a time, one burst read per line.
// Optional critical-word-first ordering is enabled by defining HARVOS_REFILL_CWF_EN.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_valid_i,
    output logic             miss_ready_o,
    input  logic [31:0]      miss_addr_i,
    input  logic             block_refill_i,
    output logic             refill_blocked_o,
    output logic             bus_req_o,
    output logic [31:0]      bus_addr_o,
    output logic [7:0]       bus_len_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [31:0]      bus_rdata_i,
    input  logic             bus_rerr_i,
    output logic             fill_we_o,
    output logic [IDX_W-1:0] fill_idx_o,
    output logic [31:0]      fill_data_o,
    output logic [31:0]      fill_line_o,
    output logic             crit_valid_o,
    output logic [31:0]      crit_data_o,
    output logic             fill_done_o,
    output logic             fill_err_o,
    output logic [31:0]      err_tval_o,
    output logic             busy_o
);

    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      line_q, line_d;
    logic [IDX_W-1:0] crit_idx_q, crit_idx_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             err_seen_q, err_seen_d;
    logic [31:0]      err_tval_q, err_tval_d;
    logic             blocked_q, blocked_d;

    logic             miss_hs_s;
    logic             beat_s;
    logic             last_beat_s;
    logic [IDX_W-1:0] start_idx_s;
    logic [IDX_W-1:0] beat_idx_s;
    logic [31:0]      req_addr_s;
    logic             unused_s;

    assign unused_s = ^miss_addr_i[1:0];

`ifdef HARVOS_REFILL_CWF_EN
    // The bus wraps within the line starting at the missed word.
    assign start_idx_s = crit_idx_q;
    assign req_addr_s  = line_q + {{(30 - IDX_W){1'b0}}, crit_idx_q, 2'b00};
`else
    assign start_idx_s = {IDX_W{1'b0}};
    assign req_addr_s  = line_q;
`endif

    assign miss_hs_s   = (state_q == S_IDLE) && miss_valid_i;
    assign beat_s      = (state_q == S_DATA) && bus_rvalid_i;
    assign last_beat_s = beat_s && (cnt_q == (IDX_W + 1)'(LINE_WORDS - 1));
    assign beat_idx_s  = start_idx_s + cnt_q[IDX_W-1:0];

    // State and datapath registers; reset aborts any refill without reporting it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            line_q     <= 32'd0;
            crit_idx_q <= {IDX_W{1'b0}};
            cnt_q      <= {(IDX_W + 1){1'b0}};
            err_seen_q <= 1'b0;
            err_tval_q <= 32'd0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            crit_idx_q <= crit_idx_d;
            cnt_q      <= cnt_d;
            err_seen_q <= err_seen_d;
            err_tval_q <= err_tval_d;
            blocked_q  <= blocked_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        crit_idx_d = crit_idx_q;
        cnt_d      = cnt_q;
        err_seen_d = err_seen_q;
        err_tval_d = err_tval_q;
        blocked_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_hs_s) begin
                    line_d     = {miss_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                    crit_idx_d = miss_addr_i[OFF_W-1:2];
                    if (block_refill_i) begin
                        blocked_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_d = S_DATA;
                    cnt_d   = {(IDX_W + 1){1'b0}};
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DATA: begin
                if (beat_s) begin
                    cnt_d = cnt_q + (IDX_W + 1)'(1);
                    // Only the first erroring beat's address is reported.
                    if (bus_rerr_i && !err_seen_q) begin
                        err_seen_d = 1'b1;
                        err_tval_d = line_q + {{(30 - IDX_W){1'b0}}, beat_idx_s, 2'b00};
                    end else begin
                        err_seen_d = err_seen_q;
                    end
                    if (last_beat_s) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                state_d    = S_IDLE;
                err_seen_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                err_seen_d = 1'b0;
            end
        endcase
    end

    // Output decode; fill and critical-word paths follow bus_rvalid_i in the same cycle.
    always_comb begin
        miss_ready_o     = 1'b0;
        refill_blocked_o = blocked_q;
        bus_req_o        = 1'b0;
        bus_addr_o       = 32'd0;
        bus_len_o        = 8'(LINE_WORDS - 1);
        fill_we_o        = 1'b0;
        fill_idx_o       = {IDX_W{1'b0}};
        fill_data_o      = 32'd0;
        fill_line_o      = line_q;
        crit_valid_o     = 1'b0;
        crit_data_o      = 32'd0;
        fill_done_o      = 1'b0;
        fill_err_o       = 1'b0;
        err_tval_o       = 32'd0;
        busy_o           = 1'b1;
        case (state_q)
            S_IDLE: begin
                miss_ready_o = 1'b1;
                busy_o       = 1'b0;
            end
            S_REQ: begin
                bus_req_o  = 1'b1;
                bus_addr_o = req_addr_s;
            end
            S_DATA: begin
                fill_idx_o   = beat_idx_s;
                fill_data_o  = bus_rdata_i;
                crit_data_o  = bus_rdata_i;
                fill_we_o    = bus_rvalid_i && !err_seen_q && !bus_rerr_i;
                crit_valid_o = bus_rvalid_i && !err_seen_q && !bus_rerr_i &&
                               (beat_idx_s == crit_idx_q);
            end
            S_RESP: begin
                if (err_seen_q) begin
                    fill_err_o = 1'b1;
                    err_tval_o = err_tval_q;
                end else begin
                    fill_done_o = 1'b1;
                end
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed, table-driven bench for icache_refill_ctrl (LINE_WORDS=8), both with and
// without HARVOS_REFILL_CWF_EN.
module tb_icache_refill_ctrl;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_addr = 32'd0;
    logic        block_refill = 1'b0;
    logic        refill_blocked;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [7:0]  bus_len;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_rerr = 1'b0;
    logic        fill_we;
    logic [2:0]  fill_idx;
    logic [31:0] fill_data;
    logic [31:0] fill_line;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        fill_done;
    logic        fill_err;
    logic [31:0] err_tval;
    logic        busy;

    icache_refill_ctrl #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_addr_i(miss_addr),
        .block_refill_i(block_refill), .refill_blocked_o(refill_blocked),
        .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_len_o(bus_len),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
        .bus_rerr_i(bus_rerr),
        .fill_we_o(fill_we), .fill_idx_o(fill_idx), .fill_data_o(fill_data),
        .fill_line_o(fill_line), .crit_valid_o(crit_valid), .crit_data_o(crit_data),
        .fill_done_o(fill_done), .fill_err_o(fill_err), .err_tval_o(err_tval),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        block;
        int          gnt_delay;
        int          err_a;
        int          err_b;
        logic [31:0] exp_bus_addr;
        logic        exp_err;
        logic [31:0] exp_tval;
    } vec_t;

    vec_t vecs[5];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic run_miss(input vec_t v);
        int   start;
        int   crit;
        int   exp_idx;
        int   we_cnt;
        int   crit_cnt;
        logic err_m;
        logic exp_we;
        logic exp_crit;
        crit = int'(v.addr[4:2]);
`ifdef HARVOS_REFILL_CWF_EN
        start = crit;
`else
        start = 0;
`endif
        cyc();
        miss_valid = 1'b1; miss_addr = v.addr; block_refill = v.block;
        #1;
        chk("miss_ready", miss_ready, 1);
        cyc();
        miss_valid = 1'b0; block_refill = 1'b0;
        #1;
        if (v.block) begin
            chk("blocked_pulse", refill_blocked, 1);
            chk("blocked_ready", miss_ready, 1);
            for (int i = 0; i < 20; i++) begin
                if (i > 0) begin
                    cyc();
                    chk("blocked_once", refill_blocked, 0);
                end
                chk("blocked_no_req", bus_req, 0);
                chk("blocked_no_we", fill_we, 0);
            end
            return;
        end
        for (int d = 0; d <= v.gnt_delay; d++) begin
            if (d > 0) cyc();
            bus_gnt    = (d == v.gnt_delay);
            bus_rvalid = (d < v.gnt_delay);
            bus_rdata  = 32'hDEAD_0000;
            #1;
            chk("req_high", bus_req, 1);
            chk("req_addr", bus_addr, v.exp_bus_addr);
            chk("req_len", bus_len, 7);
            chk("req_no_we", fill_we, 0);
        end
        err_m = 1'b0; we_cnt = 0; crit_cnt = 0;
        for (int b = 0; b < LW; b++) begin
            cyc();
            bus_gnt = 1'b0; bus_rvalid = 1'b1;
            bus_rdata = 32'hA0 + b;
            bus_rerr  = (b == v.err_a) || (b == v.err_b);
            #1;
            exp_idx  = (start + b) % LW;
            exp_we   = !err_m && !bus_rerr;
            exp_crit = exp_we && (exp_idx == crit);
            chk("fill_we", fill_we, exp_we);
            if (exp_we) begin
                chk("fill_idx", fill_idx, exp_idx);
                chk("fill_data", fill_data, 32'hA0 + b);
            end
            chk("crit_valid", crit_valid, exp_crit);
            if (exp_crit) chk("crit_data", crit_data, 32'hA0 + b);
            chk("no_early_resp", fill_done | fill_err, 0);
            if (fill_we) we_cnt++;
            if (crit_valid) crit_cnt++;
            if (bus_rerr) err_m = 1'b1;
        end
        cyc();
        bus_rvalid = 1'b0; bus_rerr = 1'b0;
        #1;
        chk("fill_done", fill_done, !v.exp_err);
        chk("fill_err", fill_err, v.exp_err);
        if (v.exp_err) chk("err_tval", err_tval, v.exp_tval);
        chk("resp_not_ready", miss_ready, 0);
        chk("we_count", we_cnt, v.exp_err ? v.err_a : LW);
        chk("crit_count", crit_cnt, 1);
        cyc();
        #1;
        chk("idle_ready", miss_ready, 1);
        chk("single_pulse", fill_done | fill_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1014, 1'b0, 0, 99, 99, 32'h0000_1000, 1'b0, 32'd0};
        vecs[1] = '{32'h8000_0000, 1'b1, 0, 99, 99, 32'h0000_0000, 1'b0, 32'd0};
        vecs[2] = '{32'h0000_2000, 1'b0, 0, 3, 5, 32'h0000_2000, 1'b1, 32'h0000_200C};
        vecs[3] = '{32'h0000_1014, 1'b0, 5, 99, 99, 32'h0000_1000, 1'b0, 32'd0};
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 1, 99, 99, 32'hFFFF_FFE0, 1'b0, 32'd0};
`ifdef HARVOS_REFILL_CWF_EN
        vecs[0].exp_bus_addr = 32'h0000_1014;
        vecs[3].exp_bus_addr = 32'h0000_1014;
        vecs[4].exp_bus_addr = 32'hFFFF_FFFC;
`endif

        #1;
        chk("rst_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_len", bus_len, 7);
        chk("rst_outs", {fill_we, crit_valid, fill_done, fill_err, refill_blocked}, 0);
        chk("rst_line", fill_line, 0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_miss(vecs[i]);

        // Reset during the fifth beat of a fill.
        cyc();
        miss_valid = 1'b1; miss_addr = 32'h0000_3000;
        cyc();
        miss_valid = 1'b0; bus_gnt = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cyc();
            bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hB0 + b;
        end
        cyc();
        bus_rdata = 32'hB4;
        #1;
        chk("pre_rst_we", fill_we, 1);
        chk("pre_rst_idx", fill_idx, 4);
        rst = 1'b1;
        #1;
        chk("async_rst_ready", miss_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_outs", {fill_we, crit_valid, fill_done, fill_err, bus_req}, 0);
        chk("async_rst_idx", fill_idx, 0);
        chk("async_rst_line", fill_line, 0);
        bus_rvalid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("post_rst_quiet", {fill_done, fill_err, bus_req}, 0);
        end
        run_miss(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
